// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one registered full-adder cell stepped LSB
// first over WIDTH clocks, with valid/ready handshakes on both sides.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  // Only WIDTH-1 partial bits are stored; the final bit is merged straight
  // into o_sum on the last step.
  logic [WIDTH-2:0] sum_sh_reg;
  logic             carry_reg;

  logic             accept;
  logic             last_step;
  logic             step_sum;
  logic             step_carry;
  logic [WIDTH-1:0] sum_shifted;

  // Handshake flags decode straight from the registered state.
  assign o_ready = (state_reg == IDLE);
  assign o_valid = (state_reg == DONE);

  assign accept    = i_valid && o_ready;
  assign last_step = (state_reg == RUN) && (cnt_reg == LAST_BIT);

  // The single full-adder cell working on the current LSBs.
  assign step_sum    = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign step_carry  = (a_sh_reg[0] & b_sh_reg[0]) |
                       (a_sh_reg[0] & carry_reg)   |
                       (b_sh_reg[0] & carry_reg);
  assign sum_shifted = {step_sum, sum_sh_reg};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the MSB,
  // DONE -> IDLE once downstream takes the result.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (i_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifters, partial sum, carry and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      a_sh_reg  <= i_a;
      b_sh_reg  <= i_sub ? ~i_b : i_b;
      carry_reg <= i_sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
      b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
      sum_sh_reg <= sum_shifted[WIDTH-1:1];
      carry_reg  <= step_carry;
      if (!last_step) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Result registers load only on entry to DONE, so they hold the last
  // result through IDLE and RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (last_step) begin
      o_sum      <= sum_shifted;
      o_carry    <= step_carry;
      o_overflow <= carry_reg ^ step_carry;
    end
  end

endmodule
